nios_multi_timer: RTL and testbench

//  Parametrised multi-channel interval timer. Avalon-MM slave on the Nios II data bus.

---
 rtl/nios_multi_timer_pkg.sv | 40 ++++
 rtl/nios_multi_timer_if.sv | 34 +++
 rtl/nios_multi_timer_ch.sv | 151 +++++++++++++++
 rtl/nios_multi_timer.sv | 108 ++++++++++
 tb/tb_nios_multi_timer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_multi_timer_pkg.sv
// nios_multi_timer_pkg
//   Shared constants for the multi-channel interval timer: per-channel register
//   offsets, CONTROL/STATUS bit positions, bus data width, the channel FSM
//   state type and the word-address width helper.
package nios_multi_timer_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 3;          // register-select bits per channel

    // Register offsets within a channel
    localparam logic [REG_W-1:0] REG_STATUS  = 3'd0;
    localparam logic [REG_W-1:0] REG_CONTROL = 3'd1;
    localparam logic [REG_W-1:0] REG_PERIOD  = 3'd2;
    localparam logic [REG_W-1:0] REG_SNAP    = 3'd3;
    localparam logic [REG_W-1:0] REG_PRESC   = 3'd4;

    // CONTROL bits
    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    // STATUS bits
    localparam int STS_TO  = 0;
    localparam int STS_RUN = 1;

    typedef enum logic {
        CH_IDLE    = 1'b0,
        CH_RUNNING = 1'b1
    } ch_state_t;

    // Word address = {channel index, register offset}
    function automatic int addr_width(input int num_ch);
        return $clog2(num_ch) + REG_W;
    endfunction

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_ADDR_W = $clog2(DEF_NUM_CH) + REG_W;

endpackage

// File: rtl/nios_multi_timer_if.sv
// nios_multi_timer_if
//   Avalon-MM slave bus of the timer (Nios II data bus side).
//   address    {channel, reg}, word address
//   chipselect slave select
//   write_n    active-low write strobe
//   read_n     active-low read strobe
//   writedata  write data
//   readdata   registered read data (1-cycle latency)
//   master modport: CPU / bench side; slave modport: timer side.
interface nios_multi_timer_if #(
    parameter int NUM_CH = 4
) ();
    import nios_multi_timer_pkg::*;

    localparam int ADDR_W = addr_width(NUM_CH);

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic              read_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        output readdata
    );

endinterface

// File: rtl/nios_multi_timer_ch.sv
// nios_multi_timer_ch
//   One timer channel: prescaler, down-counter, IDLE/RUNNING FSM, sticky
//   timeout flag, snapshot and the PERIOD/PRESC/CONTROL registers.
//   clk, reset_n     clock, asynchronous active-low reset
//   wr_*             one-cycle register write strobes for this channel
//   wdata            bus write data
//   *_rd             register read values, zero-extended to 32 bits
//   irq_ch           TO & ITO
module nios_multi_timer_ch
    import nios_multi_timer_pkg::*;
#(
    parameter int          CNT_W      = 32,
    parameter int          PRESC_W    = 8,
    parameter logic [31:0] RST_PERIOD = 32'h005F5E0F
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_status,
    input  logic              wr_control,
    input  logic              wr_period,
    input  logic              wr_snap,
    input  logic              wr_presc,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] status_rd,
    output logic [DATA_W-1:0] control_rd,
    output logic [DATA_W-1:0] period_rd,
    output logic [DATA_W-1:0] snap_rd,
    output logic [DATA_W-1:0] presc_rd,
    output logic              irq_ch
);

    localparam logic [CNT_W-1:0] PERIOD_INIT = RST_PERIOD[CNT_W-1:0];

    ch_state_t            state_reg, state_next;
    logic                 run;
    logic [CNT_W-1:0]     cnt_reg;
    logic [CNT_W-1:0]     period_reg;
    logic [CNT_W-1:0]     snap_reg;
    logic [PRESC_W-1:0]   presc_reg;
    logic [PRESC_W-1:0]   presc_act_reg;   // divider currently in use
    logic [PRESC_W-1:0]   psc_reg;
    logic                 ito_reg;
    logic                 cont_reg;
    logic                 to_reg;
    logic                 zero_d_reg;

    logic start, stop, tick, counter_zero, to_set;
    logic unused_wdata;

    assign unused_wdata = &{1'b0, wdata};

    assign start        = wr_control & wdata[CTL_START];
    assign stop         = wr_control & wdata[CTL_STOP];
    assign counter_zero = (cnt_reg == '0);
    assign tick         = run & (psc_reg == presc_act_reg);
    // One timeout event per entry into zero
    assign to_set       = counter_zero & ~zero_d_reg;

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= CH_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state (STOP overrides START in the same write)
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CH_IDLE: begin
                if (start && !stop && !wr_period) begin
                    state_next = CH_RUNNING;
                end
            end
            CH_RUNNING: begin
                if (stop || wr_period || (tick && counter_zero && !cont_reg)) begin
                    state_next = CH_IDLE;
                end
            end
            default: state_next = CH_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run = (state_reg == CH_RUNNING);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg       <= PERIOD_INIT;
            period_reg    <= PERIOD_INIT;
            snap_reg      <= '0;
            presc_reg     <= '0;
            presc_act_reg <= '0;
            psc_reg       <= '0;
            ito_reg       <= 1'b0;
            cont_reg      <= 1'b0;
            to_reg        <= 1'b0;
            zero_d_reg    <= (PERIOD_INIT == '0);
        end else begin
            if (wr_control) begin
                ito_reg  <= wdata[CTL_ITO];
                cont_reg <= wdata[CTL_CONT];
            end

            if (wr_presc) begin
                presc_reg <= wdata[PRESC_W-1:0];
            end

            // A PERIOD write forces a reload and takes priority over a tick
            if (wr_period) begin
                period_reg <= wdata[CNT_W-1:0];
                cnt_reg    <= wdata[CNT_W-1:0];
            end else if (tick) begin
                cnt_reg <= counter_zero ? period_reg : cnt_reg - CNT_W'(1);
            end

            // A new PRESC value is picked up only at a prescaler restart or wrap
            if (start || wr_period || tick) begin
                psc_reg       <= '0;
                presc_act_reg <= presc_reg;
            end else if (run) begin
                psc_reg <= psc_reg + PRESC_W'(1);
            end

            zero_d_reg <= counter_zero;

            // Set wins over a clear in the same cycle
            if (to_set) begin
                to_reg <= 1'b1;
            end else if (wr_status) begin
                to_reg <= 1'b0;
            end

            if (wr_snap) begin
                snap_reg <= cnt_reg;
            end
        end
    end

    assign status_rd  = DATA_W'({run, to_reg});
    assign control_rd = DATA_W'({cont_reg, ito_reg});
    assign period_rd  = DATA_W'(period_reg);
    assign snap_rd    = DATA_W'(snap_reg);
    assign presc_rd   = DATA_W'(presc_reg);
    assign irq_ch     = to_reg & ito_reg;

endmodule

// File: rtl/nios_multi_timer.sv
// nios_multi_timer
//   Multi-channel interval timer, Avalon-MM slave.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      Avalon-MM slave port (address/chipselect/write_n/read_n/
//            writedata/readdata)
//   irq_ch   per-channel interrupt
//   irq      OR of irq_ch
module nios_multi_timer
    import nios_multi_timer_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          CNT_W      = 32,
    parameter int          PRESC_W    = 8,
    parameter logic [31:0] RST_PERIOD = 32'h005F5E0F
) (
    input  logic                clk,
    input  logic                reset_n,
    nios_multi_timer_if.slave   bus,
    output logic [NUM_CH-1:0]   irq_ch,
    output logic                irq
);

    localparam int ADDR_W = addr_width(NUM_CH);

    logic [REG_W-1:0]  reg_sel;
    logic [ADDR_W-1:0] ch_field;
    logic              wr_en;
    logic [DATA_W-1:0] ch_rd [NUM_CH];
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] readdata_reg;
    logic              unused_read;

    // Reads have no side effects, so read_n is not needed
    assign unused_read = &{1'b0, bus.read_n};

    assign reg_sel  = bus.address[REG_W-1:0];
    // Shift rather than slice so a single-channel build still elaborates
    assign ch_field = bus.address >> REG_W;
    assign wr_en    = bus.chipselect & ~bus.write_n;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic              hit;
            logic [DATA_W-1:0] status_rd, control_rd, period_rd, snap_rd, presc_rd;
            logic [DATA_W-1:0] rd_val;

            assign hit = (ch_field == ADDR_W'(gi));

            nios_multi_timer_ch #(
                .CNT_W      (CNT_W),
                .PRESC_W    (PRESC_W),
                .RST_PERIOD (RST_PERIOD)
            ) u_ch (
                .clk        (clk),
                .reset_n    (reset_n),
                .wr_status  (wr_en & hit & (reg_sel == REG_STATUS)),
                .wr_control (wr_en & hit & (reg_sel == REG_CONTROL)),
                .wr_period  (wr_en & hit & (reg_sel == REG_PERIOD)),
                .wr_snap    (wr_en & hit & (reg_sel == REG_SNAP)),
                .wr_presc   (wr_en & hit & (reg_sel == REG_PRESC)),
                .wdata      (bus.writedata),
                .status_rd  (status_rd),
                .control_rd (control_rd),
                .period_rd  (period_rd),
                .snap_rd    (snap_rd),
                .presc_rd   (presc_rd),
                .irq_ch     (irq_ch[gi])
            );

            always_comb begin
                rd_val = '0;
                if (hit) begin
                    case (reg_sel)
                        REG_STATUS:  rd_val = status_rd;
                        REG_CONTROL: rd_val = control_rd;
                        REG_PERIOD:  rd_val = period_rd;
                        REG_SNAP:    rd_val = snap_rd;
                        REG_PRESC:   rd_val = presc_rd;
                        default:     rd_val = '0;
                    endcase
                end
            end

            assign ch_rd[gi] = rd_val;
        end
    endgenerate

    // At most one channel hits; out-of-range indices leave the OR at zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_mux = rd_mux | ch_rd[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_reg <= '0;
        end else begin
            readdata_reg <= rd_mux;
        end
    end

    assign bus.readdata = readdata_reg;
    assign irq          = |irq_ch;

endmodule

// File: tb/tb_nios_multi_timer.sv
// tb_nios_multi_timer
//   Directed bench: a table of register read/write vectors followed by
//   hand-written multi-cycle sequences (one-shot, continuous with prescaler,
//   forced reload, TO set/clear collision, multi-channel, async reset).
//   A second, 5-channel 16-bit instance covers out-of-range channel
//   addressing and width truncation.
module tb_nios_multi_timer;
    import nios_multi_timer_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] irq_ch;
    logic       irq;
    logic [4:0] irq_ch_b;
    logic       irq_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nios_multi_timer_if #(.NUM_CH(4)) bus_a ();
    nios_multi_timer_if #(.NUM_CH(5)) bus_b ();

    nios_multi_timer u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a),
        .irq_ch  (irq_ch),
        .irq     (irq)
    );

    nios_multi_timer #(
        .NUM_CH  (5),
        .CNT_W   (16),
        .PRESC_W (4)
    ) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b),
        .irq_ch  (irq_ch_b),
        .irq     (irq_b)
    );

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [4:0] aa(input int ch, input logic [2:0] r);
        return {ch[1:0], r};
    endfunction

    function automatic logic [5:0] ab(input int ch, input logic [2:0] r);
        return {ch[2:0], r};
    endfunction

    function automatic vec_t mk(input bit wr, input logic [4:0] addr, input logic [31:0] data,
                                input logic [31:0] exp, input string name);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // All bus tasks are entered at a falling edge and return at a falling edge
    task automatic bus_wr(input logic [4:0] addr, input logic [31:0] data);
        bus_a.address = addr; bus_a.writedata = data;
        bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
        @(negedge clk);
        bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [4:0] addr, output logic [31:0] data);
        bus_a.address = addr; bus_a.chipselect = 1'b1; bus_a.read_n = 1'b0;
        @(negedge clk);
        data = bus_a.readdata;
        bus_a.chipselect = 1'b0; bus_a.read_n = 1'b1;
    endtask

    task automatic wr_b(input logic [5:0] addr, input logic [31:0] data);
        bus_b.address = addr; bus_b.writedata = data;
        bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
        @(negedge clk);
        bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
    endtask

    task automatic rd_b(input logic [5:0] addr, output logic [31:0] data);
        bus_b.address = addr; bus_b.chipselect = 1'b1; bus_b.read_n = 1'b0;
        @(negedge clk);
        data = bus_b.readdata;
        bus_b.chipselect = 1'b0; bus_b.read_n = 1'b1;
    endtask

    task automatic wait_irq(input int idx, input string name, output int at_cyc);
        int n = 0;
        while (!irq_ch[idx] && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!irq_ch[idx]) begin
            n_errors++;
            $display("FAIL %s: irq_ch[%0d] got 0 expected 1 within 60 cycles", name, idx);
        end else begin
            $display("ok   %s: irq_ch[%0d] rose at cycle %0d", name, idx, cyc);
        end
        at_cyc = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rdata;
        int c1, c2, or_bad;
        int per[4];

        bus_a.address = '0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
        bus_a.read_n = 1'b1; bus_a.writedata = '0;
        bus_b.address = '0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
        bus_b.read_n = 1'b1; bus_b.writedata = '0;

        // T1: reset
        repeat (2) begin
            @(negedge clk);
            check("rst_irq_during", 32'(irq), 32'd0);
            check("rst_rd_during", bus_a.readdata, 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_irq_after", 32'(irq), 32'd0);
        check("rst_irq_ch_after", 32'(irq_ch), 32'd0);

        vecs.push_back(mk(1'b0, aa(0, REG_PERIOD),  32'h0,        32'h005F5E0F, "rst_period0"));
        vecs.push_back(mk(1'b0, aa(0, REG_STATUS),  32'h0,        32'h0,        "rst_status0"));
        vecs.push_back(mk(1'b0, aa(0, REG_CONTROL), 32'h0,        32'h0,        "rst_control0"));
        vecs.push_back(mk(1'b0, aa(0, REG_PRESC),   32'h0,        32'h0,        "rst_presc0"));
        vecs.push_back(mk(1'b0, aa(3, REG_SNAP),    32'h0,        32'h0,        "rst_snap3"));
        vecs.push_back(mk(1'b1, aa(0, REG_PERIOD),  32'h12345678, 32'h0,        ""));
        vecs.push_back(mk(1'b0, aa(0, REG_PERIOD),  32'h0,        32'h12345678, "period0_rw"));
        vecs.push_back(mk(1'b1, aa(0, REG_PRESC),   32'h000001FF, 32'h0,        ""));
        vecs.push_back(mk(1'b0, aa(0, REG_PRESC),   32'h0,        32'h000000FF, "presc0_trunc"));
        vecs.push_back(mk(1'b1, aa(0, REG_CONTROL), 32'h0000000F, 32'h0,        ""));
        vecs.push_back(mk(1'b0, aa(0, REG_CONTROL), 32'h0,        32'h00000003, "control0_strobes_rd0"));
        vecs.push_back(mk(1'b0, aa(0, REG_STATUS),  32'h0,        32'h0,        "status0_stop_wins"));
        vecs.push_back(mk(1'b1, aa(0, 3'd5),        32'hFFFFFFFF, 32'h0,        ""));
        vecs.push_back(mk(1'b0, aa(0, 3'd5),        32'h0,        32'h0,        "reg5_reads0"));
        vecs.push_back(mk(1'b1, aa(0, REG_SNAP),    32'h0,        32'h0,        ""));
        vecs.push_back(mk(1'b0, aa(0, REG_SNAP),    32'h0,        32'h12345678, "snap0_idle"));
        vecs.push_back(mk(1'b1, aa(0, REG_CONTROL), 32'h0,        32'h0,        ""));
        vecs.push_back(mk(1'b1, aa(0, REG_PRESC),   32'h0,        32'h0,        ""));
        vecs.push_back(mk(1'b0, aa(1, REG_PERIOD),  32'h0,        32'h005F5E0F, "period1_untouched"));

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                bus_wr(vecs[i].addr, vecs[i].data);
            end else begin
                bus_rd(vecs[i].addr, rdata);
                check(vecs[i].name, rdata, vecs[i].exp);
            end
        end

        // T2: one-shot on ch1, PERIOD=5, PRESC=0
        bus_wr(aa(1, REG_PERIOD), 32'd5);
        bus_wr(aa(1, REG_PRESC), 32'd0);
        bus_wr(aa(1, REG_CONTROL), 32'h5);
        repeat (5) @(negedge clk);
        check("t2_irq_ch_before", 32'(irq_ch), 32'd0);
        @(negedge clk);
        check("t2_irq_ch", 32'(irq_ch), 32'h2);
        check("t2_irq", 32'(irq), 32'd1);
        bus_rd(aa(1, REG_STATUS), rdata);
        check("t2_status", rdata, 32'h1);
        bus_wr(aa(1, REG_STATUS), 32'h0);
        check("t2_irq_cleared", 32'(irq), 32'd0);

        // T3: continuous on ch2, PERIOD=3, PRESC=2 -> timeout every 12 clk
        bus_wr(aa(2, REG_PERIOD), 32'd3);
        bus_wr(aa(2, REG_PRESC), 32'd2);
        bus_wr(aa(2, REG_CONTROL), 32'h7);
        wait_irq(2, "t3_first_to", c1);
        bus_wr(aa(2, REG_STATUS), 32'h0);
        repeat (4) @(negedge clk);
        bus_wr(aa(2, REG_SNAP), 32'h0);
        bus_rd(aa(2, REG_SNAP), rdata);
        check("t3_snap", rdata, 32'd2);
        bus_rd(aa(2, REG_STATUS), rdata);
        check("t3_status_running", rdata, 32'h2);
        wait_irq(2, "t3_second_to", c2);
        check("t3_to_interval", 32'(c2 - c1), 32'd12);

        // T4: forced reload on ch3
        bus_wr(aa(3, REG_PERIOD), 32'd100);
        bus_wr(aa(3, REG_CONTROL), 32'h4);
        repeat (3) @(negedge clk);
        bus_rd(aa(3, REG_STATUS), rdata);
        check("t4_running", rdata, 32'h2);
        bus_wr(aa(3, REG_PERIOD), 32'd50);
        bus_rd(aa(3, REG_STATUS), rdata);
        check("t4_run_cleared", rdata, 32'h0);
        bus_wr(aa(3, REG_SNAP), 32'h0);
        bus_rd(aa(3, REG_SNAP), rdata);
        check("t4_reload", rdata, 32'd50);
        bus_wr(aa(3, REG_CONTROL), 32'hC);
        repeat (3) @(negedge clk);
        bus_rd(aa(3, REG_STATUS), rdata);
        check("t4_start_stop", rdata, 32'h0);
        bus_wr(aa(3, REG_SNAP), 32'h0);
        bus_rd(aa(3, REG_SNAP), rdata);
        check("t4_hold", rdata, 32'd50);

        // T5: STATUS clear lands on the timeout edge of ch1
        bus_wr(aa(1, REG_PERIOD), 32'd4);
        bus_wr(aa(1, REG_CONTROL), 32'h5);
        repeat (4) @(negedge clk);
        bus_wr(aa(1, REG_STATUS), 32'h0);
        check("t5_irq_kept", 32'(irq_ch[1]), 32'd1);
        bus_rd(aa(1, REG_STATUS), rdata);
        check("t5_to_kept", rdata, 32'h1);

        // T6: all channels running, ch1 without ITO
        per[0] = 7; per[1] = 9; per[2] = 11; per[3] = 13;
        for (int ch = 0; ch < 4; ch++) begin
            bus_wr(aa(ch, REG_PERIOD), 32'(per[ch]));
            bus_wr(aa(ch, REG_PRESC), 32'd0);
        end
        for (int ch = 0; ch < 4; ch++) bus_wr(aa(ch, REG_STATUS), 32'h0);
        bus_wr(aa(0, REG_CONTROL), 32'h7);
        bus_wr(aa(1, REG_CONTROL), 32'h6);
        bus_wr(aa(2, REG_CONTROL), 32'h7);
        bus_wr(aa(3, REG_CONTROL), 32'h7);
        check("t6_quiet", 32'(irq_ch), 32'd0);
        or_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (irq !== (|irq_ch)) or_bad++;
        end
        check("t6_irq_or_mismatches", 32'(or_bad), 32'd0);
        check("t6_irq_ch", 32'(irq_ch), 32'hD);
        check("t6_irq", 32'(irq), 32'd1);
        bus_rd(aa(1, REG_STATUS), rdata);
        check("t6_status1", rdata, 32'h3);

        // Out-of-range channel and truncation on the 5-channel, 16-bit instance
        rd_b(ab(5, REG_PERIOD), rdata);
        check("b_ch5_read", rdata, 32'h0);
        wr_b(ab(5, REG_PERIOD), 32'h00001234);
        rd_b(ab(5, REG_PERIOD), rdata);
        check("b_ch5_write_ignored", rdata, 32'h0);
        rd_b(ab(4, REG_PERIOD), rdata);
        check("b_rst_period_trunc", rdata, 32'h00005E0F);
        wr_b(ab(4, REG_PERIOD), 32'hABCD1234);
        rd_b(ab(4, REG_PERIOD), rdata);
        check("b_period_trunc", rdata, 32'h00001234);
        wr_b(ab(4, REG_PRESC), 32'h000000F7);
        rd_b(ab(4, REG_PRESC), rdata);
        check("b_presc_trunc", rdata, 32'h00000007);
        check("b_irq", 32'(irq_b), 32'd0);

        // Asynchronous reset mid-count
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_irq_ch", 32'(irq_ch), 32'd0);
        check("t6_async_irq", 32'(irq), 32'd0);
        check("t6_async_readdata", bus_a.readdata, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_rd(aa(2, REG_STATUS), rdata);
        check("t6_run_cleared", rdata, 32'h0);
        bus_rd(aa(2, REG_PERIOD), rdata);
        check("t6_period_reset", rdata, 32'h005F5E0F);
        repeat (20) @(negedge clk);
        check("t6_stays_idle", 32'(irq_ch), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
